// File: rtl/usb_host_pkg.sv
// Shared definitions for the host receive path: owner codes, PID values,
// router FSM states and the PID self-check helper.
package usb_host_pkg;

    localparam logic [1:0] OWNER_ENUM     = 2'd0;
    localparam logic [1:0] OWNER_TRANS    = 2'd1;
    localparam logic [1:0] OWNER_PROTOCOL = 2'd2;
    localparam logic [1:0] OWNER_TOKEN    = 2'd3;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_DATA2 = 4'b0111;
    localparam logic [3:0] PID_MDATA = 4'b1111;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [3:0] PID_NYET  = 4'b0110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_RECV,
        ST_DRAIN
    } rx_state_e;

    // A PID byte carries its own check: upper nibble is the complement of the lower.
    function automatic logic pid_byte_ok(input logic [7:0] pid_byte);
        return pid_byte[7:4] == ~pid_byte[3:0];
    endfunction

endpackage

// File: rtl/usb_host_rx_router_if.sv
// PHY receive stream, transmit-done notification and routed receive bus
// seen by the receive router (slave) and its environment (master).
interface usb_host_rx_router_if;

    logic [7:0] phy_rx_data;
    logic       phy_rx_valid;
    logic       phy_rx_active;
    logic       phy_rx_error;
    logic       tx_done;
    logic [1:0] tx_owner;

    logic [1:0] rx_dest;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_sop;
    logic       rx_eop;
    logic       rx_err;
    logic [3:0] rx_pid;
    logic       rx_timeout;
    logic       rx_busy;
    logic [7:0] unsolicited_cnt;

    modport slave (
        input  phy_rx_data, phy_rx_valid, phy_rx_active, phy_rx_error, tx_done, tx_owner,
        output rx_dest, rx_data, rx_valid, rx_sop, rx_eop, rx_err, rx_pid,
               rx_timeout, rx_busy, unsolicited_cnt
    );

    modport master (
        output phy_rx_data, phy_rx_valid, phy_rx_active, phy_rx_error, tx_done, tx_owner,
        input  rx_dest, rx_data, rx_valid, rx_sop, rx_eop, rx_err, rx_pid,
               rx_timeout, rx_busy, unsolicited_cnt
    );

endinterface

// File: rtl/usb_rx_pid_check.sv
// Combinational PID check: validity of the nibble-complement pair and the
// PID value carried in the lower nibble.
module usb_rx_pid_check
    import usb_host_pkg::*;
(
    input  logic [7:0] pid_byte_i,
    output logic       pid_valid_o,
    output logic [3:0] pid_o
);

    assign pid_valid_o = pid_byte_ok(pid_byte_i);
    assign pid_o       = pid_byte_i[3:0];

endmodule

// File: rtl/usb_host_rx_router.sv
// Routes each PHY receive packet to the host sub-block that last transmitted,
// enforcing turnaround timeout, PID check and babble; unsolicited packets are counted.
module usb_host_rx_router
    import usb_host_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 96,
    parameter int unsigned MAX_BYTES      = 1027
) (
    input logic                 clk,
    input logic                 rst,
    usb_host_rx_router_if.slave bus
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned BW = $clog2(MAX_BYTES + 1);

    rx_state_e     state_q, state_d;
    logic          active_q;
    logic [TW-1:0] timer_q, timer_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          err_q, err_d;
    logic [1:0]    dest_q, dest_d;
    logic [3:0]    pid_q, pid_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          sop_q, sop_d;
    logic          eop_q, eop_d;
    logic          rxerr_q, rxerr_d;
    logic          tout_q, tout_d;
    logic [7:0]    ucnt_q, ucnt_d;

    logic          active_rise;
    logic          in_packet;
    logic          pid_ok;
    logic [3:0]    pid_nib;

    usb_rx_pid_check u_pid_check (
        .pid_byte_i  (bus.phy_rx_data),
        .pid_valid_o (pid_ok),
        .pid_o       (pid_nib)
    );

    assign active_rise = bus.phy_rx_active & ~active_q;
    // ARMED also accepts bytes so a packet whose first byte lands with the rising edge is kept.
    assign in_packet   = ((state_q == ST_ARMED) || (state_q == ST_RECV)) && bus.phy_rx_active;

    always_comb begin
        // NOTE: every variable gets a default first so no path through the block can infer a latch.
        state_d = state_q;
        timer_d = timer_q;
        bcnt_d  = bcnt_q;
        err_d   = err_q;
        dest_d  = dest_q;
        pid_d   = pid_q;
        data_d  = data_q;
        valid_d = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        rxerr_d = 1'b0;
        tout_d  = 1'b0;
        ucnt_d  = ucnt_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.tx_done) begin
                    dest_d  = bus.tx_owner;
                    timer_d = '0;
                    bcnt_d  = '0;
                    err_d   = 1'b0;
                    state_d = ST_ARMED;
                end else if (active_rise) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_ARMED: begin
                timer_d = timer_q + TW'(1);
                if (bus.phy_rx_active) begin
                    state_d = ST_RECV;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    tout_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (!bus.phy_rx_active) begin
                    eop_d   = 1'b1;
                    rxerr_d = err_q | bus.phy_rx_error | (bcnt_q == '0);
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (!bus.phy_rx_active) begin
                    if (ucnt_q != 8'hFF) ucnt_d = ucnt_q + 8'd1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (in_packet) begin
            if (bus.phy_rx_error) err_d = 1'b1;
            if (bus.phy_rx_valid) begin
                if (bcnt_q == BW'(MAX_BYTES)) begin
                    err_d = 1'b1;
                end else begin
                    data_d  = bus.phy_rx_data;
                    valid_d = 1'b1;
                    sop_d   = (bcnt_q == '0);
                    bcnt_d  = bcnt_q + BW'(1);
                    if (bcnt_q == '0) begin
                        pid_d = pid_nib;
                        if (!pid_ok) err_d = 1'b1;
                    end
                end
            end
        end
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values regardless of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            bcnt_q  <= '0;
            err_q   <= 1'b0;
            dest_q  <= '0;
            pid_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            rxerr_q <= 1'b0;
            tout_q  <= 1'b0;
            ucnt_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bcnt_q  <= bcnt_d;
            err_q   <= err_d;
            dest_q  <= dest_d;
            pid_q   <= pid_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            rxerr_q <= rxerr_d;
            tout_q  <= tout_d;
            ucnt_q  <= ucnt_d;
        end
    end

    // Tracked through reset so a packet already in flight is not mistaken for a new one.
    always_ff @(posedge clk) begin
        active_q <= bus.phy_rx_active;
    end

    assign bus.rx_dest         = dest_q;
    assign bus.rx_data         = data_q;
    assign bus.rx_valid        = valid_q;
    assign bus.rx_sop          = sop_q;
    assign bus.rx_eop          = eop_q;
    assign bus.rx_err          = rxerr_q;
    assign bus.rx_pid          = pid_q;
    assign bus.rx_timeout      = tout_q;
    assign bus.rx_busy         = (state_q == ST_ARMED) || (state_q == ST_RECV);
    assign bus.unsolicited_cnt = ucnt_q;

endmodule

// File: tb/tb_usb_host_rx_router.sv
// Self-checking bench for usb_host_rx_router: PID vector table, scoreboard of
// forwarded bytes, and hand-written timeout / babble / reset / unsolicited sequences.
module tb_usb_host_rx_router;
    import usb_host_pkg::*;

    localparam int unsigned TIMEOUT_CYCLES = 96;
    localparam int unsigned MAX_BYTES      = 1027;

    typedef struct {
        logic [1:0] owner;
        logic [7:0] pid_byte;
        logic       exp_err;
        logic [3:0] exp_pid;
    } pid_vec_t;

    logic       clk = 1'b0;
    logic       rst;
    int         total = 0;
    int         bad = 0;
    int         fwd_cnt = 0;
    int         eop_cnt = 0;
    logic       last_err = 1'b0;
    logic [8:0] exp_q[$];

    usb_host_rx_router_if bus();

    usb_host_rx_router #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .MAX_BYTES      (MAX_BYTES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {4'd0, bus.rx_dest, bus.rx_data, bus.rx_valid, bus.rx_sop, bus.rx_eop,
                bus.rx_err, bus.rx_pid, bus.rx_timeout, bus.rx_busy, bus.unsolicited_cnt};
    endfunction

    // Scoreboard consumer: every forwarded byte must match the next expected {sop, data}.
    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) begin
            fwd_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_byte: got data 0x%0h sop %0b with nothing expected",
                         bus.rx_data, bus.rx_sop);
            end else begin
                check("fwd_byte", {23'd0, bus.rx_sop, bus.rx_data}, {23'd0, exp_q.pop_front()});
            end
        end
        if (bus.rx_eop === 1'b1) begin
            eop_cnt++;
            last_err = bus.rx_err;
            check("eop_without_valid", {31'd0, bus.rx_valid}, 32'd0);
        end else if (bus.rx_err === 1'b1) begin
            total++;
            bad++;
            $display("FAIL err_without_eop: got rx_err 1 with rx_eop 0");
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tx(input logic [1:0] owner);
        bus.tx_done  = 1'b1;
        bus.tx_owner = owner;
        tick();
        bus.tx_done  = 1'b0;
    endtask

    // Drives bytes with phy_rx_active already high, then drops active; base is the packet index of b[0].
    task automatic send_body(input logic [7:0] b[$], input bit routed, input int base);
        foreach (b[i]) begin
            bus.phy_rx_valid = 1'b1;
            bus.phy_rx_data  = b[i];
            if (routed && (base + i) < int'(MAX_BYTES))
                exp_q.push_back({logic'((base + i) == 0), b[i]});
            tick();
        end
        bus.phy_rx_valid  = 1'b0;
        bus.phy_rx_active = 1'b0;
        tick();
        if (routed) check("eop_latency", {31'd0, bus.rx_eop}, 32'd1);
        repeat (2) tick();
    endtask

    task automatic send_pkt(input logic [7:0] b[$], input bit routed);
        bus.phy_rx_active = 1'b1;
        tick();
        send_body(b, routed, 0);
    endtask

    initial begin
        pid_vec_t   vecs[6];
        logic [7:0] pkt[$];
        int         eop0;
        int         fwd0;
        int         seen;
        logic       busy_prev;

        vecs[0] = '{owner: OWNER_ENUM,     pid_byte: 8'hC4, exp_err: 1'b1, exp_pid: 4'h4};
        vecs[1] = '{owner: OWNER_PROTOCOL, pid_byte: 8'h69, exp_err: 1'b0, exp_pid: 4'h9};
        vecs[2] = '{owner: OWNER_TOKEN,    pid_byte: 8'hD2, exp_err: 1'b0, exp_pid: 4'h2};
        vecs[3] = '{owner: OWNER_TRANS,    pid_byte: 8'hA5, exp_err: 1'b0, exp_pid: 4'h5};
        vecs[4] = '{owner: OWNER_PROTOCOL, pid_byte: 8'h00, exp_err: 1'b1, exp_pid: 4'h0};
        vecs[5] = '{owner: OWNER_ENUM,     pid_byte: 8'hFF, exp_err: 1'b1, exp_pid: 4'hF};

        rst               = 1'b1;
        bus.phy_rx_data   = 8'h00;
        bus.phy_rx_valid  = 1'b0;
        bus.phy_rx_active = 1'b0;
        bus.phy_rx_error  = 1'b0;
        bus.tx_done       = 1'b0;
        bus.tx_owner      = 2'd0;
        repeat (3) tick();
        check("reset_outputs", all_outs(), 32'd0);
        rst = 1'b0;
        tick();

        // Basic routed packet with explicit one-cycle data latency.
        eop0 = eop_cnt;
        pulse_tx(OWNER_TRANS);
        check("t1_dest", {30'd0, bus.rx_dest}, 32'd1);
        check("t1_busy_armed", {31'd0, bus.rx_busy}, 32'd1);
        bus.phy_rx_active = 1'b1;
        tick();
        bus.phy_rx_valid = 1'b1;
        bus.phy_rx_data  = 8'hC3;
        exp_q.push_back({1'b1, 8'hC3});
        tick();
        check("t1_first_byte", {22'd0, bus.rx_valid, bus.rx_sop, bus.rx_data}, {22'd0, 1'b1, 1'b1, 8'hC3});
        pkt = {8'h01, 8'h02, 8'hF0, 8'h0D};
        send_body(pkt, 1'b1, 1);
        check("t1_eop_count", eop_cnt - eop0, 32'd1);
        check("t1_err", {31'd0, last_err}, 32'd0);
        check("t1_pid", {28'd0, bus.rx_pid}, 32'd3);
        check("t1_dest_hold", {30'd0, bus.rx_dest}, 32'd1);
        check("t1_busy_idle", {31'd0, bus.rx_busy}, 32'd0);

        // PID vectors.
        foreach (vecs[v]) begin
            eop0 = eop_cnt;
            pulse_tx(vecs[v].owner);
            pkt = {vecs[v].pid_byte, 8'h55};
            send_pkt(pkt, 1'b1);
            check("pid_eop_count", eop_cnt - eop0, 32'd1);
            check("pid_err", {31'd0, last_err}, {31'd0, vecs[v].exp_err});
            check("pid_value", {28'd0, bus.rx_pid}, {28'd0, vecs[v].exp_pid});
            check("pid_dest", {30'd0, bus.rx_dest}, {30'd0, vecs[v].owner});
        end

        // Turnaround timeout.
        pulse_tx(OWNER_TOKEN);
        seen = 0;
        busy_prev = 1'b0;
        for (int i = 1; i <= 200 && seen == 0; i++) begin
            busy_prev = bus.rx_busy;
            tick();
            if (bus.rx_timeout) seen = i;
        end
        check("timeout_cycles", seen, TIMEOUT_CYCLES);
        check("timeout_dest", {30'd0, bus.rx_dest}, 32'd3);
        check("timeout_busy_before", {31'd0, busy_prev}, 32'd1);
        tick();
        check("timeout_single_pulse", {31'd0, bus.rx_timeout}, 32'd0);
        check("timeout_busy_after", {31'd0, bus.rx_busy}, 32'd0);

        // Zero-byte packet is an error.
        eop0 = eop_cnt;
        pulse_tx(OWNER_PROTOCOL);
        bus.phy_rx_active = 1'b1;
        repeat (2) tick();
        pkt.delete();
        send_body(pkt, 1'b1, 0);
        check("empty_eop_count", eop_cnt - eop0, 32'd1);
        check("empty_err", {31'd0, last_err}, 32'd1);

        // PHY decode error in the middle of a packet with a good PID.
        pulse_tx(OWNER_TRANS);
        bus.phy_rx_active = 1'b1;
        tick();
        bus.phy_rx_valid = 1'b1;
        bus.phy_rx_data  = 8'h4B;
        exp_q.push_back({1'b1, 8'h4B});
        tick();
        bus.phy_rx_valid = 1'b0;
        bus.phy_rx_error = 1'b1;
        tick();
        bus.phy_rx_error = 1'b0;
        pkt = {8'h11};
        send_body(pkt, 1'b1, 1);
        check("phyerr_err", {31'd0, last_err}, 32'd1);
        check("phyerr_pid", {28'd0, bus.rx_pid}, 32'hB);

        // tx_done coincident with phy_rx_active rising: routed, not drained.
        eop0 = eop_cnt;
        bus.tx_done       = 1'b1;
        bus.tx_owner      = OWNER_PROTOCOL;
        bus.phy_rx_active = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        pkt = {8'h4B, 8'hAA, 8'hBB};
        send_body(pkt, 1'b1, 0);
        check("coinc_eop_count", eop_cnt - eop0, 32'd1);
        check("coinc_err", {31'd0, last_err}, 32'd0);
        check("coinc_dest", {30'd0, bus.rx_dest}, 32'd2);
        check("coinc_not_drained", {24'd0, bus.unsolicited_cnt}, 32'd0);

        // Babble: 1030 bytes offered, 1027 forwarded.
        pulse_tx(OWNER_PROTOCOL);
        fwd0 = fwd_cnt;
        pkt.delete();
        pkt.push_back(8'h4B);
        for (int i = 1; i < 1030; i++) pkt.push_back(8'(i));
        send_pkt(pkt, 1'b1);
        check("babble_fwd_count", fwd_cnt - fwd0, MAX_BYTES);
        check("babble_err", {31'd0, last_err}, 32'd1);
        check("babble_sb_empty", exp_q.size(), 32'd0);

        // Reset in the middle of RECV; the truncated packet gets no eop and is not counted.
        pulse_tx(OWNER_TRANS);
        bus.phy_rx_active = 1'b1;
        tick();
        bus.phy_rx_valid = 1'b1;
        bus.phy_rx_data  = 8'hC3;
        exp_q.push_back({1'b1, 8'hC3});
        tick();
        bus.phy_rx_data = 8'h01;
        exp_q.push_back({1'b0, 8'h01});
        tick();
        eop0 = eop_cnt;
        bus.phy_rx_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("midrst_outputs", all_outs(), 32'd0);
        rst = 1'b0;
        repeat (3) tick();
        bus.phy_rx_active = 1'b0;
        repeat (3) tick();
        check("midrst_no_eop", eop_cnt - eop0, 32'd0);
        check("midrst_not_counted", {24'd0, bus.unsolicited_cnt}, 32'd0);

        // Unsolicited packets: never forwarded, counter saturates.
        fwd0 = fwd_cnt;
        pkt = {8'hC3, 8'h01, 8'h02};
        send_pkt(pkt, 1'b0);
        check("unsol_count_1", {24'd0, bus.unsolicited_cnt}, 32'd1);
        for (int n = 1; n < 300; n++) send_pkt(pkt, 1'b0);
        check("unsol_saturated", {24'd0, bus.unsolicited_cnt}, 32'd255);
        check("unsol_no_forward", fwd_cnt - fwd0, 32'd0);
        check("final_sb_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
